// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// clocks-per-bit arithmetic used by both the receiver and the transmitter.
package uart_pkg;

  // Receiver FSM state encoding (3-bit, kept as plain constants for legacy users)
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  // 8N1 frame shape
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Clocks per bit; integer division truncates, matching the transmitter.
  function automatic int unsigned calc_bit_time(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Clocks from the start-bit falling edge to the start-bit midpoint.
  function automatic int unsigned calc_half_bit(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
    return calc_bit_time(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so idle-high lines (like a UART rx) do not glitch out of reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the async input through two flops; only sync_q is safe to use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Each bit is sampled at its midpoint using cycle-count
// timing; received bytes are held in rx_data with a valid/ack handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned CLOCK_FREQ = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int unsigned BIT_TIME = calc_bit_time(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT = calc_half_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned IDX_W    = $clog2(DATA_BITS);

  localparam logic [15:0]      BIT_LAST  = 16'(BIT_TIME - 1);
  localparam logic [15:0]      HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // The bit counter is 16 bits wide and the FSM needs at least a few clocks per bit.
  if (BIT_TIME > 65535 || BIT_TIME < 4) begin : g_bad_bit_time
    $error("uart_rx: BIT_TIME must be within 4..65535");
  end

  logic             rx_s;
  logic [2:0]       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             ovr_q, ovr_d;
  logic             load_good;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Next-state logic for the frame FSM and the output handshake.
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load_good = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          // Still low at the midpoint: a real start bit; otherwise a glitch.
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          // LSB arrives first, so shifting right leaves it in bit 0.
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            load_good = 1'b1;
            state_d   = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it cannot look like a stream of frames.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load in the same cycle as an ack wins: valid stays set, no overrun.
    data_d  = load_good ? shift_q : data_q;
    valid_d = valid_q;
    if (valid_q && rx_ack) begin
      valid_d = 1'b0;
    end
    if (load_good) begin
      valid_d = 1'b1;
    end
    ovr_d = load_good && valid_q && !rx_ack;
  end

  // State and output registers; reset abandons any partial frame silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_busy      = (state_q != IDLE);
  assign rx_frame_err = err_q;
  assign rx_overrun   = ovr_q;

endmodule
